// File: rtl/spec_readout_streamer.sv
// rtl/spec_readout_streamer.sv - reads accumulated spectra from DPRAM and streams header + words to host
module spec_readout_streamer #(
  parameter int BINS_PER_RANGE   = 1024,
  parameter int MAX_RANGE_BINS   = 16,
  parameter int ADDR_W           = 14,
  parameter int RD_LATENCY       = 1,
  parameter int FIFO_DEPTH       = 4,
  parameter int CLEAR_AFTER_READ = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [4:0]        nof_bins_i,
  input  logic [15:0]       pulse_cnt_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [31:0]       rd_data_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [15:0]       y0_o,
  output logic [15:0]       y0z_o,
  output logic              sof_o,
  output logic              eof_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int BW = $clog2(BINS_PER_RANGE);
  localparam int RW = ADDR_W - BW;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;
  localparam int WW = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, HEADER, STREAM, DRAIN} state_t;
  state_t state_q, state_d;

  logic [4:0]            n_q;
  logic [15:0]           pulse_q;
  logic [RW-1:0]         range_cnt;
  logic [BW-1:0]         bin_cnt;
  logic [WW-1:0]         word_cnt;
  logic [WW-1:0]         last_idx;
  logic [RD_LATENCY-1:0] pipe_v;
  logic [ADDR_W-1:0]     pipe_a [RD_LATENCY];
  logic [31:0]           fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         fifo_count, in_flight;
  logic [31:0]           out_word;
  logic [4:0]            n_clamped;
  logic                  done_q, issue, room, is_last_addr, flush, push, pop, accept;

  assign n_clamped    = (int'(nof_bins_i) > MAX_RANGE_BINS) ? 5'(MAX_RANGE_BINS) : nof_bins_i;
  assign last_idx     = (WW'(n_q) << BW) - WW'(1);
  assign is_last_addr = (int'(range_cnt) == int'(n_q) - 1) && (&bin_cnt);
  assign room         = (fifo_count + in_flight) < CW'(FIFO_DEPTH);
  assign flush        = abort_i && (state_q != IDLE);
  assign push         = pipe_v[RD_LATENCY-1];
  assign accept       = valid_o && ready_i && !abort_i;
  assign pop          = accept && (state_q == STREAM || state_q == DRAIN);

  assign rd_addr_o = {range_cnt, bin_cnt};
  assign wr_en_o   = (CLEAR_AFTER_READ != 0) && pipe_v[RD_LATENCY-1];
  assign wr_addr_o = pipe_a[RD_LATENCY-1];
  assign wr_data_o = 32'h0;
  assign y0_o      = out_word[15:0];
  assign y0z_o     = out_word[31:16];
  assign busy_o    = (state_q != IDLE);
  assign done_o    = done_q;

  // Reads still travelling through the RAM pipeline count against FIFO space
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LATENCY; i++) in_flight = in_flight + CW'(pipe_v[i]);
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state, read issue and output word selection
  always_comb begin
    state_d  = state_q;
    valid_o  = 1'b0;
    sof_o    = 1'b0;
    eof_o    = 1'b0;
    out_word = 32'h0;
    issue    = 1'b0;
    case (state_q)
      IDLE: if (start_i) state_d = HEADER;
      HEADER: begin
        valid_o  = 1'b1;
        sof_o    = 1'b1;
        eof_o    = (n_q == 5'd0);
        out_word = {pulse_q, 11'b0, n_q};
        issue    = (n_q != 5'd0) && room;
        if (ready_i) state_d = (n_q == 5'd0) ? IDLE : STREAM;
      end
      STREAM, DRAIN: begin
        valid_o = (fifo_count != '0);
        if (valid_o) begin
          out_word = fifo_mem[rd_ptr];
          eof_o    = (word_cnt == last_idx);
        end
        if (state_q == STREAM) begin
          issue = room;
          if (room && is_last_addr) state_d = DRAIN;
        end else if (valid_o && eof_o && ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // abort beats any acceptance or issue in the same cycle
    if (abort_i && state_q != IDLE) begin
      state_d = IDLE;
      issue   = 1'b0;
    end
  end

  // Frame parameters, address/word counters, read pipeline and FIFO pointers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      n_q        <= '0;
      pulse_q    <= '0;
      range_cnt  <= '0;
      bin_cnt    <= '0;
      word_cnt   <= '0;
      pipe_v     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      done_q     <= 1'b0;
      for (int i = 0; i < RD_LATENCY; i++) pipe_a[i] <= '0;
    end else begin
      done_q    <= accept && eof_o;
      pipe_v[0] <= issue;
      pipe_a[0] <= rd_addr_o;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_a[i] <= pipe_a[i-1];
      end
      if (state_q == IDLE && start_i) begin
        n_q       <= n_clamped;
        pulse_q   <= pulse_cnt_i;
        range_cnt <= '0;
        bin_cnt   <= '0;
        word_cnt  <= '0;
      end else begin
        if (issue) begin
          bin_cnt <= bin_cnt + BW'(1);
          if (&bin_cnt) range_cnt <= range_cnt + RW'(1);
        end
        if (pop) word_cnt <= word_cnt + WW'(1);
      end
      if (flush) begin
        pipe_v     <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
      end else begin
        if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
        if (pop)  rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
    end
  end

  // FIFO storage; returned data lands here exactly when its pipeline slot matures
  always_ff @(posedge clk_i) begin
    if (push && !flush) fifo_mem[wr_ptr] <= rd_data_i;
  end

endmodule

// File: tb/tb_spec_readout_streamer.sv
// tb/tb_spec_readout_streamer.sv - directed self-checking bench for spec_readout_streamer
module tb_spec_readout_streamer;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1, start_i = 1'b0, abort_i = 1'b0, ready_i = 1'b1;
  logic [4:0]  nof_bins_i = '0;
  logic [15:0] pulse_cnt_i = '0;
  logic [13:0] rd_addr_o, wr_addr_o;
  logic [31:0] rd_data_i, wr_data_o;
  logic        wr_en_o, valid_o, sof_o, eof_o, busy_o, done_o;
  logic [15:0] y0_o, y0z_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [16384];
  logic [31:0] fill_xor = '0;
  int          fill_seq = 0, fill_ack = 0;
  logic [13:0] wr_log [$];
  int          wr_data_bad = 0;

  logic [31:0] got_w [$];
  bit          got_sof [$];
  bit          got_eof [$];
  int          got_cyc [$];
  int          done_cyc, stall_changes;
  bit          timed_out;

  spec_readout_streamer dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .nof_bins_i(nof_bins_i), .pulse_cnt_i(pulse_cnt_i),
    .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .ready_i(ready_i), .valid_o(valid_o), .y0_o(y0_o), .y0z_o(y0z_o),
    .sof_o(sof_o), .eof_o(eof_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  // DPRAM model: 1-cycle port-B read, port-A zero writes, bulk fill on request
  always @(posedge clk) begin
    if (fill_seq != fill_ack) begin
      for (int a = 0; a < 16384; a++) mem[a] <= 32'(a) ^ fill_xor;
      fill_ack <= fill_seq;
    end else if (wr_en_o) begin
      mem[wr_addr_o] <= 32'h0;
    end
    rd_data_i <= mem[rd_addr_o];
  end

  // Log of clear writes
  always @(posedge clk) begin
    if (!rst_i && wr_en_o) begin
      wr_log.push_back(wr_addr_o);
      if (wr_data_o !== 32'h0) wr_data_bad++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] x);
    fill_xor = x;
    fill_seq++;
    tick();
    tick();
  endtask

  task automatic start_frame(input logic [4:0] nb, input logic [15:0] pulse);
    nof_bins_i  = nb;
    pulse_cnt_i = pulse;
    start_i     = 1'b1;
    tick();
    start_i     = 1'b0;
  endtask

  task automatic capture(input int max_cyc, input bit rnd);
    logic [34:0] prev;
    bit          prev_stall;
    prev = '0;
    prev_stall = 1'b0;
    got_w.delete(); got_sof.delete(); got_eof.delete(); got_cyc.delete();
    done_cyc = -1; stall_changes = 0; timed_out = 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      if (done_o) begin
        done_cyc  = c;
        timed_out = 1'b0;
        break;
      end
      if (prev_stall && {valid_o, sof_o, eof_o, y0z_o, y0_o} != prev) stall_changes++;
      ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (valid_o && ready_i) begin
        got_w.push_back({y0z_o, y0_o});
        got_sof.push_back(sof_o);
        got_eof.push_back(eof_o);
        got_cyc.push_back(c);
      end
      prev_stall = valid_o && !ready_i;
      prev = {valid_o, sof_o, eof_o, y0z_o, y0_o};
      tick();
    end
    ready_i = 1'b1;
  endtask

  function automatic int data_errs(input logic [31:0] x);
    int bad = 0;
    for (int i = 1; i < got_w.size(); i++)
      if (got_w[i] !== (32'(i - 1) ^ x)) bad++;
    return bad;
  endfunction

  function automatic int framing_errs();
    int bad = 0;
    for (int i = 0; i < got_w.size(); i++) begin
      if (got_sof[i] !== (i == 0)) bad++;
      if (got_eof[i] !== (i == got_w.size() - 1)) bad++;
    end
    return bad;
  endfunction

  function automatic logic [31:0] head_word();
    return (got_w.size() > 0) ? got_w[0] : 32'hxxxx_xxxx;
  endfunction

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) tick();
    rst_i = 1'b0;
    checks++;
    if ({valid_o, sof_o, eof_o, busy_o, done_o, wr_en_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000", {valid_o, sof_o, eof_o, busy_o, done_o, wr_en_o});
    end
    checks++;
    if ({rd_addr_o, wr_addr_o, wr_data_o, y0z_o, y0_o} !== '0) begin
      errors++;
      $display("FAIL reset_buses: rd_addr=%0h wr_addr=%0h wr_data=%0h y=%0h expected all 0", rd_addr_o, wr_addr_o, wr_data_o, {y0z_o, y0_o});
    end
  endtask

  task automatic test_single_range();
    int base, gaps;
    fill(32'h0);
    base = wr_log.size();
    start_frame(5'd1, 16'h1234);
    capture(3000, 1'b0);
    checks++;
    if (timed_out) begin errors++; $display("FAIL t1_done_timeout: no done within 3000 cycles"); end
    checks++;
    if (got_w.size() != 1025) begin errors++; $display("FAIL t1_count: got %0d words expected 1025", got_w.size()); end
    checks++;
    if (head_word() !== 32'h1234_0001) begin errors++; $display("FAIL t1_header: got %h expected 12340001", head_word()); end
    checks++;
    if (data_errs(32'h0) != 0) begin errors++; $display("FAIL t1_data: %0d bad words expected 0", data_errs(32'h0)); end
    gaps = 0;
    for (int i = 0; i < got_cyc.size(); i++)
      if (got_cyc[i] != ((i == 0) ? 0 : i + 1)) gaps++;
    checks++;
    if (gaps != 0) begin errors++; $display("FAIL t1_timing: %0d words off schedule expected 0", gaps); end
    checks++;
    if (framing_errs() != 0) begin errors++; $display("FAIL t1_framing: %0d sof/eof errors expected 0", framing_errs()); end
    checks++;
    if (got_cyc.size() == 0 || done_cyc != got_cyc[got_cyc.size() - 1] + 1) begin
      errors++; $display("FAIL t1_done_cycle: got %0d expected one after last word", done_cyc);
    end
    checks++;
    if (wr_log.size() - base != 1024) begin errors++; $display("FAIL t1_clears: got %0d expected 1024", wr_log.size() - base); end
  endtask

  task automatic test_empty_frame();
    int base;
    fill(32'h0011_0000);
    base = wr_log.size();
    start_frame(5'd0, 16'hABCD);
    capture(50, 1'b0);
    checks++;
    if (timed_out || done_cyc != 1) begin errors++; $display("FAIL t2_done: got cycle %0d expected 1", done_cyc); end
    checks++;
    if (got_w.size() != 1 || head_word() !== 32'hABCD_0000) begin
      errors++; $display("FAIL t2_header: got %0d words head %h expected 1 word abcd0000", got_w.size(), head_word());
    end
    checks++;
    if (framing_errs() != 0) begin errors++; $display("FAIL t2_sof_eof: %0d errors expected 0", framing_errs()); end
    checks++;
    if (wr_log.size() != base) begin errors++; $display("FAIL t2_no_writes: got %0d expected 0", wr_log.size() - base); end
  endtask

  task automatic test_backpressure();
    fill(32'h3C00_0000);
    start_frame(5'd16, 16'h0F0F);
    capture(70000, 1'b1);
    checks++;
    if (timed_out) begin errors++; $display("FAIL t3_done_timeout: no done within 70000 cycles"); end
    checks++;
    if (got_w.size() != 16385) begin errors++; $display("FAIL t3_count: got %0d expected 16385", got_w.size()); end
    checks++;
    if (head_word() !== 32'h0F0F_0010) begin errors++; $display("FAIL t3_header: got %h expected 0f0f0010", head_word()); end
    checks++;
    if (data_errs(32'h3C00_0000) != 0) begin errors++; $display("FAIL t3_data: %0d bad words expected 0", data_errs(32'h3C00_0000)); end
    checks++;
    if (framing_errs() != 0) begin errors++; $display("FAIL t3_framing: %0d errors expected 0", framing_errs()); end
    checks++;
    if (stall_changes != 0) begin errors++; $display("FAIL t3_stable: %0d changes while stalled expected 0", stall_changes); end
  endtask

  task automatic test_clear();
    int base, order_bad, nz, touched;
    fill(32'h5A5A_0000);
    base = wr_log.size();
    start_frame(5'd2, 16'h0002);
    capture(5000, 1'b0);
    checks++;
    if (timed_out || got_w.size() != 2049) begin errors++; $display("FAIL t4_frame: got %0d words expected 2049", got_w.size()); end
    checks++;
    if (data_errs(32'h5A5A_0000) != 0) begin errors++; $display("FAIL t4_read_before_clear: %0d bad words expected 0", data_errs(32'h5A5A_0000)); end
    order_bad = 0;
    for (int i = base; i < wr_log.size(); i++)
      if (wr_log[i] !== 14'(i - base)) order_bad++;
    checks++;
    if (wr_log.size() - base != 2048 || order_bad != 0) begin
      errors++; $display("FAIL t4_clear_seq: got %0d clears %0d out of order expected 2048 and 0", wr_log.size() - base, order_bad);
    end
    nz = 0; touched = 0;
    for (int a = 0; a < 2048; a++) if (mem[a] !== 32'h0) nz++;
    for (int a = 2048; a < 16384; a++) if (mem[a] !== (32'(a) ^ 32'h5A5A_0000)) touched++;
    checks++;
    if (nz != 0) begin errors++; $display("FAIL t4_zeroed: %0d nonzero locations expected 0", nz); end
    checks++;
    if (touched != 0) begin errors++; $display("FAIL t4_untouched: %0d altered locations expected 0", touched); end
    checks++;
    if (wr_data_bad != 0) begin errors++; $display("FAIL t4_wr_data: %0d nonzero writes expected 0", wr_data_bad); end
  endtask

  task automatic test_abort();
    int  nw, bad, dones, vals;
    bit  aborted;
    fill(32'h0);
    start_frame(5'd2, 16'h0505);
    nw = 0; bad = 0; aborted = 1'b0;
    for (int c = 0; c < 3000 && !aborted; c++) begin
      if (valid_o && !sof_o && nw == 500) begin
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        aborted = 1'b1;
      end else begin
        if (valid_o && !sof_o) begin
          if ({y0z_o, y0_o} !== 32'(nw)) bad++;
          nw++;
        end
        tick();
      end
    end
    checks++;
    if (!aborted || bad != 0) begin errors++; $display("FAIL t5_pre_abort: reached=%0d bad=%0d expected 1 and 0", aborted, bad); end
    checks++;
    if ({valid_o, busy_o, wr_en_o} !== 3'b000) begin errors++; $display("FAIL t5_after_abort: valid/busy/wr_en=%b expected 000", {valid_o, busy_o, wr_en_o}); end
    dones = 0; vals = 0;
    repeat (8) begin
      if (done_o) dones++;
      if (valid_o) vals++;
      tick();
    end
    checks++;
    if (dones != 0 || vals != 0) begin errors++; $display("FAIL t5_quiet: done=%0d valid=%0d expected 0 and 0", dones, vals); end
    fill(32'h0077_0000);
    start_frame(5'd1, 16'h0606);
    capture(3000, 1'b0);
    checks++;
    if (head_word() !== 32'h0606_0001 || got_w.size() != 1025) begin
      errors++; $display("FAIL t5_restart_header: got %h with %0d words expected 06060001 with 1025", head_word(), got_w.size());
    end
    checks++;
    if (data_errs(32'h0077_0000) != 0 || framing_errs() != 0) begin
      errors++; $display("FAIL t5_restart_data: %0d data %0d framing errors expected 0", data_errs(32'h0077_0000), framing_errs());
    end
  endtask

  task automatic test_clamp_and_reset();
    int nw, bad, extra_sof, stray;
    fill(32'h0);
    start_frame(5'd20, 16'hBEEF);
    checks++;
    if ({y0z_o, y0_o} !== 32'hBEEF_0010 || sof_o !== 1'b1) begin
      errors++; $display("FAIL t6_clamp: got %h sof=%b expected beef0010 sof=1", {y0z_o, y0_o}, sof_o);
    end
    nw = 0; bad = 0; extra_sof = 0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0 && sof_o) extra_sof++;
      if (valid_o && !sof_o) begin
        if ({y0z_o, y0_o} !== 32'(nw)) bad++;
        nw++;
      end
      nof_bins_i = 5'd1;
      start_i = (c == 20);
      tick();
    end
    start_i = 1'b0;
    checks++;
    if (nw != 38 || bad != 0 || extra_sof != 0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL t6_start_ignored: words=%0d bad=%0d sof=%0d busy=%b expected 38 0 0 1", nw, bad, extra_sof, busy_o);
    end
    rst_i = 1'b1;
    tick();
    checks++;
    if ({valid_o, sof_o, eof_o, busy_o, done_o, wr_en_o, rd_addr_o, wr_addr_o, y0z_o, y0_o} !== '0) begin
      errors++; $display("FAIL t6_mid_reset: valid=%b busy=%b y=%h rd_addr=%0h expected all 0", valid_o, busy_o, {y0z_o, y0_o}, rd_addr_o);
    end
    rst_i = 1'b0;
    stray = 0;
    repeat (6) begin
      tick();
      if (done_o || valid_o || eof_o) stray++;
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL t6_after_reset: %0d stray cycles expected 0", stray); end
  endtask

  initial begin
    test_reset();
    test_single_range();
    test_empty_frame();
    test_backpressure();
    test_clear();
    test_abort();
    test_clamp_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
